vmerge_wb: RTL and testbench
============================

VMERGE_WB -- requirements
Module: vmerge_wb

Interface
REQ-001 SHALL have parameter VLEN, default 128, giving the vector register width in bits.
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port i_valid, input, 1, upstream result valid.
REQ-005 SHALL have port o_ready, output, 1, block can accept an entry.
REQ-006 SHALL have port i_sew, input, 11, element width in bits; legal values 8, 16, 32, 64, 128.
REQ-007 SHALL have port i_result, input, VLEN, vector ALU result.
REQ-008 SHALL have port i_old, input, VLEN, prior destination-register contents.
REQ-009 SHALL have port i_mask, input, VLEN/8, one mask bit per element index.
REQ-010 SHALL have port i_vm, input, 1, where 1 means unmasked.
REQ-011 SHALL have port i_vl, input, $clog2(VLEN/8)+1, active element count.
REQ-012 SHALL have port i_vd, input, 5, destination register address.
REQ-013 SHALL have port o_valid, output, 1, write-back entry valid.
REQ-014 SHALL have port i_ready, input, 1, register file accepts the entry.
REQ-015 SHALL have port o_wdata, output, VLEN, merged write data.
REQ-016 SHALL have port o_waddr, output, 5, destination address.
REQ-017 SHALL have port o_err, output, 1, entry carried an illegal SEW.

Function
REQ-018 SHALL treat element e (width SEW, bits e*SEW upward) as active when e < i_vl and (i_vm=1 or i_mask[e]=1).
REQ-019 SHALL classify e as masked-off body when e < i_vl and it is not active.
REQ-020 SHALL classify e as tail when e >= i_vl.
REQ-021 SHALL take active elements from i_result and masked-off body elements from i_old.
REQ-022 SHALL fill tail elements as set out in Configuration.
REQ-023 SHALL treat all elements as body when i_vl >= VLEN/SEW, and all elements as tail when i_vl = 0.
REQ-024 SHALL, for illegal i_sew, store o_wdata = i_old unchanged with o_err = 1 for that entry, and o_err = 0 otherwise.
REQ-025 SHALL store entries in a 2-entry FIFO holding {wdata, waddr, err}; the merge is computed combinationally and written at accept.
REQ-026 SHALL accept an entry on a rising edge where i_valid=1 and o_ready=1.
REQ-027 SHALL drive o_ready as a register-only function: 1 when FIFO occupancy < 2, never derived from i_ready.
REQ-028 SHALL drive o_valid = 1 when occupancy != 0, with o_wdata, o_waddr and o_err showing the head entry; no input-to-output bypass.
REQ-029 SHALL have latency exactly 1 cycle: an entry accepted at edge N gives o_valid=1 after edge N.
REQ-030 SHALL pop the head on an edge where o_valid=1 and i_ready=1.
REQ-031 SHALL, on simultaneous push and pop at occupancy 1, keep occupancy 1 with the new entry at the head.
REQ-032 SHALL, at occupancy 2, not push; a pop there lowers occupancy to 1 and o_ready rises next cycle.
REQ-033 SHALL hold head outputs stable while o_valid=1 and i_ready=0.
REQ-034 SHALL wrap the read and write pointers modulo 2 and preserve FIFO order.

Reset
REQ-035 SHALL, while i_rst_n=0, force occupancy 0, pointers 0, o_valid 0, o_ready 1, o_wdata 0, o_waddr 0, o_err 0, immediately and regardless of i_clk.
REQ-036 SHALL discard in-flight entries on reset mid-operation; nothing is emitted after release until a new accept.

Configuration
REQ-037 SHALL, with macro VMERGE_TAIL_AGNOSTIC_EN defined, write tail elements as all ones.
REQ-038 SHALL, without VMERGE_TAIL_AGNOSTIC_EN, write tail elements from i_old (tail-undisturbed).

Verification (VLEN=128)
REQ-039 SHALL cover: SEW=8, vl=16, vm=1, result=all 0xAA, vd=3 -> next cycle o_valid=1, o_wdata=all 0xAA, o_waddr=3, o_err=0.
REQ-040 SHALL cover: SEW=32, vl=2, vm=1, result words 0x11111111, old words 0x22222222 -> words 0-1 = 0x11111111; words 2-3 = 0x22222222, or 0xFFFFFFFF with the macro.
REQ-041 SHALL cover: SEW=16, vl=8, vm=0, mask=0x0055, result halves 0xBEEF, old halves 0x0000 -> halves 0,2,4,6 = 0xBEEF; 1,3,5,7 = 0x0000.
REQ-042 SHALL cover: i_ready=0 with three back-to-back entries A,B,C -> o_ready=0 after A and B are accepted, C is held; i_ready=1 -> A, B, C emitted in order, one per cycle.
REQ-043 SHALL cover: i_sew=11'h3, old=all 0x5A -> o_wdata=all 0x5A, o_err=1.
REQ-044 SHALL cover: two entries queued, i_rst_n pulsed low mid-cycle -> o_valid=0 and o_ready=1 immediately, and nothing is emitted after release.

Source files
------------

// File: rtl/vmerge_wb.sv
// vmerge_wb: vector mask/tail merge ahead of the register-file write-back port.
//
// Each accepted entry is merged combinationally and then stored in a 2-entry
// FIFO of {wdata, waddr, err}. The head entry drives the outputs directly from
// storage, so no input reaches an output within the same cycle.
//
// Build option:
//   VMERGE_TAIL_AGNOSTIC_EN  defined     -> tail elements are written as all ones
//                            not defined -> tail elements keep i_old (tail-undisturbed)
module vmerge_wb #(
    parameter int unsigned VLEN = 128
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [10:0]                 i_sew,
    input  logic [VLEN-1:0]             i_result,
    input  logic [VLEN-1:0]             i_old,
    input  logic [VLEN/8-1:0]           i_mask,
    input  logic                        i_vm,
    input  logic [$clog2(VLEN/8):0]     i_vl,
    input  logic [4:0]                  i_vd,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [VLEN-1:0]             o_wdata,
    output logic [4:0]                  o_waddr,
    output logic                        o_err
);

    localparam int unsigned NB  = VLEN / 8;      // bytes per register
    localparam int unsigned MW  = $clog2(NB);    // mask index width
    localparam int unsigned VLW = MW + 1;        // element index / vl width

    logic [VLEN-1:0] merged;
    logic            merge_err;

    // Storage for the two FIFO slots
    logic [VLEN-1:0] mem_wdata [2];
    logic [4:0]      mem_waddr [2];
    logic            mem_err   [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      count;

    logic push;
    logic pop;

    // Per-byte merge: each byte inherits the classification of the element it belongs to
    always_comb begin
        int unsigned     k;
        logic            legal;
        logic [VLW-1:0]  eidx;
        logic [MW-1:0]   midx;
        logic            body;
        logic            active;

        k      = 0;
        legal  = 1'b1;
        eidx   = '0;
        midx   = '0;
        body   = 1'b0;
        active = 1'b0;
        merged = i_old;

        case (i_sew)
            11'd8:   k = 0;
            11'd16:  k = 1;
            11'd32:  k = 2;
            11'd64:  k = 3;
            11'd128: k = 4;
            default: legal = 1'b0;
        endcase
        // An element wider than the register cannot be addressed either
        if ({21'd0, i_sew} > VLEN)
            legal = 1'b0;

        merge_err = ~legal;

        if (legal) begin
            for (int unsigned b = 0; b < NB; b++) begin
                eidx   = VLW'(b >> k);
                midx   = MW'(b >> k);
                body   = (eidx < i_vl);
                active = body && (i_vm || i_mask[midx]);
                if (active)
                    merged[b*8 +: 8] = i_result[b*8 +: 8];
                else if (!body) begin
`ifdef VMERGE_TAIL_AGNOSTIC_EN
                    merged[b*8 +: 8] = 8'hFF;
`else
                    merged[b*8 +: 8] = i_old[b*8 +: 8];
`endif
                end
            end
        end
    end

    assign o_ready = (count != 2'd2);
    assign o_valid = (count != 2'd0);
    assign push    = i_valid && o_ready;
    assign pop     = o_valid && i_ready;

    assign o_wdata = mem_wdata[rd_ptr];
    assign o_waddr = mem_waddr[rd_ptr];
    assign o_err   = mem_err[rd_ptr];

    // FIFO pointers, occupancy and slot writes; slots are cleared on reset so the
    // head outputs read zero while reset is held
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem_wdata[i] <= '0;
                mem_waddr[i] <= '0;
                mem_err[i]   <= 1'b0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_wdata[wr_ptr] <= merged;
                mem_waddr[wr_ptr] <= i_vd;
                mem_err[wr_ptr]   <= merge_err;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_vmerge_wb.sv
// Directed testbench for vmerge_wb (VLEN=128).
module tb_vmerge_wb;

    localparam int unsigned VLEN = 128;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_valid;
    logic             o_ready;
    logic [10:0]      i_sew;
    logic [VLEN-1:0]  i_result;
    logic [VLEN-1:0]  i_old;
    logic [15:0]      i_mask;
    logic             i_vm;
    logic [4:0]       i_vl;
    logic [4:0]       i_vd;
    logic             o_valid;
    logic             i_ready;
    logic [VLEN-1:0]  o_wdata;
    logic [4:0]       o_waddr;
    logic             o_err;

    int checks = 0;
    int errors = 0;

    vmerge_wb #(.VLEN(VLEN)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_sew    (i_sew),
        .i_result (i_result),
        .i_old    (i_old),
        .i_mask   (i_mask),
        .i_vm     (i_vm),
        .i_vl     (i_vl),
        .i_vd     (i_vd),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_wdata  (o_wdata),
        .o_waddr  (o_waddr),
        .o_err    (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Present one entry on the input side (valid held until the caller drops it)
    task automatic drive(input logic [10:0] sew, input logic [VLEN-1:0] res,
                         input logic [VLEN-1:0] old, input logic [15:0] mask,
                         input logic vm, input logic [4:0] vl, input logic [4:0] vd);
        i_valid  = 1'b1;
        i_sew    = sew;
        i_result = res;
        i_old    = old;
        i_mask   = mask;
        i_vm     = vm;
        i_vl     = vl;
        i_vd     = vd;
    endtask

    // Wait for one rising edge and return at the following falling edge
    task automatic step();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        #2;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", o_ready); end
        checks++; if (o_wdata !== '0) begin errors++; $display("FAIL reset_wdata got %h want 0", o_wdata); end
        checks++; if (o_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr got %0d want 0", o_waddr); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", o_err); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic test_sew8_full();
        i_ready = 1'b0;
        drive(11'd8, {16{8'hAA}}, '0, 16'h0000, 1'b1, 5'd16, 5'd3);
        @(posedge i_clk);
        #1;
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL sew8_latency_valid got %b want 1", o_valid); end
        @(negedge i_clk);
        i_valid = 1'b0;
        checks++; if (o_wdata !== {16{8'hAA}}) begin errors++; $display("FAIL sew8_wdata got %h want %h", o_wdata, {16{8'hAA}}); end
        checks++; if (o_waddr !== 5'd3) begin errors++; $display("FAIL sew8_waddr got %0d want 3", o_waddr); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL sew8_err got %b want 0", o_err); end
        i_ready = 1'b1;
        step();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL sew8_pop_valid got %b want 0", o_valid); end
    endtask

    task automatic test_tail();
        logic [VLEN-1:0] exp;
`ifdef VMERGE_TAIL_AGNOSTIC_EN
        exp = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'h11111111, 32'h11111111};
`else
        exp = {32'h22222222, 32'h22222222, 32'h11111111, 32'h11111111};
`endif
        i_ready = 1'b0;
        drive(11'd32, {4{32'h11111111}}, {4{32'h22222222}}, 16'h0000, 1'b1, 5'd2, 5'd7);
        step();
        i_valid = 1'b0;
        checks++; if (o_wdata !== exp) begin errors++; $display("FAIL tail32_wdata got %h want %h", o_wdata, exp); end
        checks++; if (o_waddr !== 5'd7) begin errors++; $display("FAIL tail32_waddr got %0d want 7", o_waddr); end
        i_ready = 1'b1;
        step();
    endtask

    task automatic test_mask();
        logic [VLEN-1:0] exp;
        exp = {4{16'h0000, 16'hBEEF}};
        i_ready = 1'b0;
        drive(11'd16, {8{16'hBEEF}}, '0, 16'h0055, 1'b0, 5'd8, 5'd9);
        step();
        i_valid = 1'b0;
        checks++; if (o_wdata !== exp) begin errors++; $display("FAIL mask16_wdata got %h want %h", o_wdata, exp); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL mask16_err got %b want 0", o_err); end
        i_ready = 1'b1;
        step();
    endtask

    task automatic test_vl_zero();
        logic [VLEN-1:0] exp;
`ifdef VMERGE_TAIL_AGNOSTIC_EN
        exp = {VLEN{1'b1}};
`else
        exp = {16{8'h33}};
`endif
        i_ready = 1'b0;
        drive(11'd8, {16{8'hCC}}, {16{8'h33}}, 16'hFFFF, 1'b1, 5'd0, 5'd1);
        step();
        i_valid = 1'b0;
        checks++; if (o_wdata !== exp) begin errors++; $display("FAIL vl0_wdata got %h want %h", o_wdata, exp); end
        i_ready = 1'b1;
        step();
    endtask

    task automatic test_wide_sew();
        logic [VLEN-1:0] exp;
        // SEW=64, vl=1, mask bit0 set: element 0 active, element 1 tail
`ifdef VMERGE_TAIL_AGNOSTIC_EN
        exp = {64'hFFFFFFFF_FFFFFFFF, 64'h0123456789ABCDEF};
`else
        exp = {64'h5555555555555555, 64'h0123456789ABCDEF};
`endif
        i_ready = 1'b0;
        drive(11'd64, {64'hFEDCBA9876543210, 64'h0123456789ABCDEF}, {2{64'h5555555555555555}},
              16'h0001, 1'b0, 5'd1, 5'd12);
        step();
        i_valid = 1'b0;
        checks++; if (o_wdata !== exp) begin errors++; $display("FAIL sew64_wdata got %h want %h", o_wdata, exp); end
        i_ready = 1'b1;
        step();
        // SEW=128, vl larger than element count, mask bit0 clear: whole register masked off
        i_ready = 1'b0;
        drive(11'd128, {VLEN{1'b1}}, {16{8'h96}}, 16'hFFFE, 1'b0, 5'd16, 5'd13);
        step();
        i_valid = 1'b0;
        checks++; if (o_wdata !== {16{8'h96}}) begin errors++; $display("FAIL sew128_masked_wdata got %h want %h", o_wdata, {16{8'h96}}); end
        i_ready = 1'b1;
        step();
    endtask

    task automatic test_illegal_sew();
        i_ready = 1'b0;
        drive(11'h3, {16{8'hC3}}, {16{8'h5A}}, 16'hFFFF, 1'b1, 5'd16, 5'd21);
        step();
        i_valid = 1'b0;
        checks++; if (o_wdata !== {16{8'h5A}}) begin errors++; $display("FAIL illegal_wdata got %h want %h", o_wdata, {16{8'h5A}}); end
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL illegal_err got %b want 1", o_err); end
        checks++; if (o_waddr !== 5'd21) begin errors++; $display("FAIL illegal_waddr got %0d want 21", o_waddr); end
        i_ready = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        i_ready = 1'b0;
        drive(11'd8, {16{8'h01}}, '0, 16'h0000, 1'b1, 5'd16, 5'd1);   // A
        step();
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_a got %b want 1", o_ready); end
        drive(11'd8, {16{8'h02}}, '0, 16'h0000, 1'b1, 5'd16, 5'd2);   // B
        step();
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full got %b want 0", o_ready); end
        drive(11'd8, {16{8'h04}}, '0, 16'h0000, 1'b1, 5'd16, 5'd4);   // C, must be held
        step();
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_held got %b want 0", o_ready); end
        checks++; if (o_waddr !== 5'd1 || o_wdata !== {16{8'h01}}) begin errors++; $display("FAIL b2b_head_a got %0d/%h want 1/%h", o_waddr, o_wdata, {16{8'h01}}); end
        i_ready = 1'b1;
        step();   // A popped, C not pushed
        checks++; if (o_waddr !== 5'd2 || o_wdata !== {16{8'h02}}) begin errors++; $display("FAIL b2b_head_b got %0d/%h want 2/%h", o_waddr, o_wdata, {16{8'h02}}); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_rise got %b want 1", o_ready); end
        step();   // push C, pop B at occupancy 1
        i_valid = 1'b0;
        checks++; if (o_valid !== 1'b1 || o_waddr !== 5'd4 || o_wdata !== {16{8'h04}}) begin errors++; $display("FAIL b2b_head_c got %b/%0d/%h want 1/4/%h", o_valid, o_waddr, o_wdata, {16{8'h04}}); end
        step();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b want 0", o_valid); end
    endtask

    task automatic test_reset_mid();
        i_ready = 1'b0;
        drive(11'd8, {16{8'hE1}}, '0, 16'h0000, 1'b1, 5'd16, 5'd5);
        step();
        drive(11'd8, {16{8'hE2}}, '0, 16'h0000, 1'b1, 5'd16, 5'd6);
        step();
        i_valid = 1'b0;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL rstmid_full got %b want 0", o_ready); end
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL rstmid_async got valid %b ready %b want 0 1", o_valid, o_ready); end
        checks++; if (o_wdata !== '0 || o_waddr !== 5'd0) begin errors++; $display("FAIL rstmid_data got %h/%0d want 0/0", o_wdata, o_waddr); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after%0d got %b want 0", i, o_valid); end
        end
    endtask

    initial begin
        i_rst_n  = 1'b0;
        i_valid  = 1'b0;
        i_sew    = 11'd8;
        i_result = '0;
        i_old    = '0;
        i_mask   = '0;
        i_vm     = 1'b1;
        i_vl     = '0;
        i_vd     = '0;
        i_ready  = 1'b0;

        test_reset();
        test_sew8_full();
        test_tail();
        test_mask();
        test_vl_zero();
        test_wide_sew();
        test_illegal_sew();
        test_back_to_back();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
